// File: rtl/id_ex_elastic_reg.sv
// id_ex_elastic_reg: ID->EXE pipeline register with a valid/ready handshake and a two-entry skid buffer.
// Latency 1 cycle (input accepted at edge N is visible after edge N); throughput 1/cycle.
// Backpressure: in_ready and out_valid come straight from flops, with no combinational path from out_ready.
//
// Ports:
//   clk, rst (synchronous, active-low), flush (squash every held entry)
//   in_valid/in_ready  + pc_in, val1_in, val2_in, reg2_in, dest_in, src1_in, src2_in,
//                        exe_cmd_in, br_taken_in, mem_r_en_in, mem_w_en_in, wb_en_in
//   out_valid/out_ready + pc_out, val1, val2, reg2, dest, src1, src2,
//                        exe_cmd, br_taken, mem_r_en, mem_w_en, wb_en
//   level: occupancy 0..2
module id_ex_elastic_reg #(
  parameter int DATA_W               = 32,
  parameter int REG_AW               = 5,
  parameter int CMD_W                = 4,
  parameter bit CLEAR_DATA_ON_BUBBLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val1_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] reg2_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic              br_taken_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] reg2,
  output logic [REG_AW-1:0] dest,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic [CMD_W-1:0]  exe_cmd,
  output logic              br_taken,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en,
  output logic [1:0]        level
);

  // Control fields occupy the low bits of the packed payload so a bubble
  // can zero them with a single mask.
  localparam int CTRL_W = CMD_W + 4;
  localparam int PAY_W  = 4*DATA_W + 3*REG_AW + CTRL_W;

  // Encodings double as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       level_q;
  logic             in_fire;
  logic             out_fire;

  assign in_pay = {pc_in, val1_in, val2_in, reg2_in, dest_in, src1_in, src2_in,
                   exe_cmd_in, br_taken_in, mem_r_en_in, mem_w_en_in, wb_en_in};

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Payload left in the main register when it goes invalid: control is
  // always cleared so a valid-unaware EXE stage sees a NOP; data is
  // optionally cleared as well.
  function automatic logic [PAY_W-1:0] bubble(input logic [PAY_W-1:0] p);
    logic [PAY_W-1:0] r;
    if (CLEAR_DATA_ON_BUBBLE) begin
      r = '0;
    end else begin
      r = {p[PAY_W-1:CTRL_W], {CTRL_W{1'b0}}};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_d  = in_pay;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_pay;
        end else if (in_fire) begin
          skid_d  = in_pay;
          state_d = S_FULL;
        end else if (out_fire) begin
          main_d  = bubble(main_q);
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the output side can move.
        if (out_fire) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
    // Squash overrides every transition; a same-cycle in_fire is dropped.
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = bubble(main_q);
      skid_d  = '0;
    end
  end

  // Handshake outputs are registered from the next state so neither side
  // sees a combinational path through this block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      level_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
      level_q     <= state_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign {pc_out, val1, val2, reg2, dest, src1, src2,
          exe_cmd, br_taken, mem_r_en, mem_w_en, wb_en} = main_q;

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
module tb_id_ex_elastic_reg;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int CW  = 4;
  localparam int CTW = CW + 4;
  localparam int PW  = 4*DW + 3*AW + CTW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, out_ready;
  logic [PW-1:0] in_vec;

  logic [DW-1:0] pc_in, val1_in, val2_in, reg2_in;
  logic [AW-1:0] dest_in, src1_in, src2_in;
  logic [CW-1:0] exe_cmd_in;
  logic          br_taken_in, mem_r_en_in, mem_w_en_in, wb_en_in;
  assign {pc_in, val1_in, val2_in, reg2_in, dest_in, src1_in, src2_in,
          exe_cmd_in, br_taken_in, mem_r_en_in, mem_w_en_in, wb_en_in} = in_vec;

  // Instance 0: data holds on bubble
  logic          in_ready0, out_valid0;
  logic [DW-1:0] pc0, v1_0, v2_0, r2_0;
  logic [AW-1:0] d0, s1_0, s2_0;
  logic [CW-1:0] cmd0;
  logic          br0, mr0, mw0, wb0;
  logic [1:0]    level0;
  logic [PW-1:0] obs0;
  assign obs0 = {pc0, v1_0, v2_0, r2_0, d0, s1_0, s2_0, cmd0, br0, mr0, mw0, wb0};

  // Instance 1: data cleared on bubble
  logic          in_ready1, out_valid1;
  logic [DW-1:0] pc1, v1_1, v2_1, r2_1;
  logic [AW-1:0] d1, s1_1, s2_1;
  logic [CW-1:0] cmd1;
  logic          br1, mr1, mw1, wb1;
  logic [1:0]    level1;
  logic [PW-1:0] obs1;
  assign obs1 = {pc1, v1_1, v2_1, r2_1, d1, s1_1, s2_1, cmd1, br1, mr1, mw1, wb1};

  id_ex_elastic_reg #(.DATA_W(DW), .REG_AW(AW), .CMD_W(CW), .CLEAR_DATA_ON_BUBBLE(1'b0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .pc_in(pc_in), .val1_in(val1_in), .val2_in(val2_in), .reg2_in(reg2_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .exe_cmd_in(exe_cmd_in),
    .br_taken_in(br_taken_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .wb_en_in(wb_en_in), .out_valid(out_valid0), .out_ready(out_ready),
    .pc_out(pc0), .val1(v1_0), .val2(v2_0), .reg2(r2_0), .dest(d0), .src1(s1_0),
    .src2(s2_0), .exe_cmd(cmd0), .br_taken(br0), .mem_r_en(mr0), .mem_w_en(mw0),
    .wb_en(wb0), .level(level0));

  id_ex_elastic_reg #(.DATA_W(DW), .REG_AW(AW), .CMD_W(CW), .CLEAR_DATA_ON_BUBBLE(1'b1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .pc_in(pc_in), .val1_in(val1_in), .val2_in(val2_in), .reg2_in(reg2_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .exe_cmd_in(exe_cmd_in),
    .br_taken_in(br_taken_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .wb_en_in(wb_en_in), .out_valid(out_valid1), .out_ready(out_ready),
    .pc_out(pc1), .val1(v1_1), .val2(v2_1), .reg2(r2_1), .dest(d1), .src1(s1_1),
    .src2(s2_1), .exe_cmd(cmd1), .br_taken(br1), .mem_r_en(mr1), .mem_w_en(mw1),
    .wb_en(wb1), .level(level1));

  int            vecs = 0;
  int            errs = 0;
  logic [PW-1:0] q[$];
  logic [PW-1:0] last_data = '0;
  bit            chk = 1'b0;

  task automatic cmp(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] pc);
    logic [PW-1:0] v;
    v = PW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    v[PW-1 -: DW] = pc;
    return v;
  endfunction

  // One clock: check outputs against the reference queue, then advance the
  // reference with this cycle's handshakes. Called just after a negedge.
  task automatic cycle();
    bit of, inf;
    int n;
    #1;
    n = q.size();
    if (chk) begin
      cmp("level0",    PW'(level0),     PW'(n));
      cmp("level1",    PW'(level1),     PW'(n));
      cmp("in_ready",  PW'(in_ready0),  PW'(n < 2));
      cmp("out_valid", PW'(out_valid0), PW'(n != 0));
      cmp("out_valid1", PW'(out_valid1), PW'(n != 0));
      if (n != 0) begin
        cmp("head0", obs0, q[0]);
        cmp("head1", obs1, q[0]);
        last_data = q[0];
      end else begin
        cmp("bubble_ctrl0", PW'(obs0[CTW-1:0]), '0);
        cmp("hold_data0",   PW'(obs0[PW-1:CTW]), PW'(last_data[PW-1:CTW]));
        cmp("clear_all1",   obs1, '0);
      end
    end
    if (!rst) begin
      q.delete();
      last_data = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      of  = (n != 0) && out_ready;
      inf = in_valid && (n < 2);
      if (of)  void'(q.pop_front());
      if (inf) q.push_back(in_vec);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one instruction and hold it until the reference accepts it.
  task automatic send(input logic [31:0] pc);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_vec   = mk(pc);
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = (q.size() < 2);
      cycle();
    end
    if (!acc) cmp("send_timeout", PW'(0), PW'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    in_vec = mk(32'h0); in_vec[0] = 1'b1;           // wb_en_in=1 during reset
    cycle();
    chk = 1'b1;
    cycle();
    rst = 1'b1; in_valid = 1'b0;
    cycle();

    // Streaming
    out_ready = 1'b1;
    send(32'h00); send(32'h04); send(32'h08);
    cycle(); cycle();

    // Backpressure, held input, stability while full
    out_ready = 1'b0;
    send(32'h10); send(32'h14);
    in_valid = 1'b1; in_vec = mk(32'h18);
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1'b1;
    send(32'h18);                                    // re-presents 0x18 until accepted
    cycle(); cycle(); cycle();

    // Flush with simultaneous input
    out_ready = 1'b0;
    send(32'h30); send(32'h34);
    flush = 1'b1; in_valid = 1'b1; in_vec = mk(32'h20);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    cycle(); cycle();
    out_ready = 1'b1;
    send(32'h40);
    cycle(); cycle();

    // Flush coinciding with an output fire in ONE
    send(32'h50);
    out_ready = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_vec    = mk(32'h1000 + 32'(i) * 4);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cycle(); cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/id_ex_elastic_reg.md
Name: id_ex_elastic_reg

Overview:
- Parametrised ID→EXE pipeline register with a valid/ready handshake and a two-entry skid buffer, so each side's ready is driven from a register.
- Adds features the plain ID/EX latch lacks:
  - backpressure from EXE;
  - synchronous flush for branch squash;
  - bubble encoding, so a valid-unaware EXE stage stays safe;
  - source register addresses for forwarding.
- Sits between decode and execute.

Parameters:
- DATA_W, 32, width of PC, Val1, Val2, Reg2.
- REG_AW, 5, register address width for dest/src1/src2.
- CMD_W, 4, EXE command width.
- CLEAR_DATA_ON_BUBBLE, 0: if 1, data fields are also zeroed whenever out_valid=0. If 0, data fields hold.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  squash all held entries (branch taken in EXE).
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  buffer can accept (skid entry empty).
- pc_in, val1_in, val2_in, reg2_in  in  DATA_W each  decode payload.
- dest_in, src1_in, src2_in  in  REG_AW each  register addresses.
- exe_cmd_in  in  CMD_W  ALU command.
- br_taken_in, mem_r_en_in, mem_w_en_in, wb_en_in  in  1 each  control bits.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EXE accepts head entry.
- pc_out, val1, val2, reg2  out  DATA_W each  head payload.
- dest, src1, src2  out  REG_AW each.
- exe_cmd  out  CMD_W.
- br_taken, mem_r_en, mem_w_en, wb_en  out  1 each.
- level  out  2  occupancy, 0..2.

Behaviour:
- Reset (rst=0 at a rising edge):
  - All state and outputs go to 0, except in_ready, which is 1 from the first cycle after reset.
  - Input valid/ready and flush are ignored while rst=0.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = ~skid_valid, driven from a register with no combinational path from out_ready.
  - out_valid = main_valid, also from a register.
- States:
  - EMPTY: level 0, main and skid invalid.
  - ONE: level 1, main valid.
  - FULL: level 2, main and skid valid, in_ready=0.
- Transitions (no flush):
  - EMPTY: in_fire → ONE, main<=input. Otherwise stay.
  - ONE, in_fire & out_fire → ONE, main<=input.
  - ONE, in_fire & ~out_fire → FULL, skid<=input.
  - ONE, ~in_fire & out_fire → EMPTY.
  - ONE, neither → hold.
  - FULL: out_fire → ONE, main<=skid, skid cleared. Otherwise hold.
- Order: strict FIFO. Minimum latency is 1 cycle, input at edge N → out_valid after edge N. Sustained throughput is 1 per cycle when out_ready=1.
- Flush (priority below reset, above everything else):
  - Next state EMPTY, level 0.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the same cycle counts as consumed by EXE.
  - in_ready is 1 the cycle after.
- Bubble invariant: whenever out_valid=0, exe_cmd, br_taken, mem_r_en, mem_w_en and wb_en are all 0. This holds after reset, after flush, and after draining to EMPTY.
  - Data fields are zeroed too if CLEAR_DATA_ON_BUBBLE=1, otherwise they hold their last value.
- Stability: while out_valid=1 and out_ready=0, every output is stable.
- No arithmetic. All fields are passed bit-exact at their parameter widths.
- Held-input rule: a valid input held while in_ready=0 is captured on the first cycle in_ready=1. It is neither duplicated nor lost.

Test Plan:
- Reset/bubble: hold rst=0 for 2 cycles with in_valid=1 and wb_en_in=1, then release → out_valid=0, wb_en=0, level=0, in_ready=1; no capture during reset.
- Streaming: out_ready=1, send PC 0x00, 0x04, 0x08 back-to-back → pc_out shows 0x00, 0x04, 0x08 on consecutive cycles, each one cycle after input; level stays 1.
- Backpressure: out_ready=0, send 0x10 then 0x14 → level=2, in_ready=0. Then 0x18 is held on the input; release out_ready → output order 0x10, 0x14, 0x18, none lost or duplicated.
- Stability: FULL with out_ready=0 for 5 cycles → all outputs constant, level=2.
- Flush with simultaneous input: FULL state, assert flush and in_valid with PC 0x20 → next cycle out_valid=0, level=0, control outputs 0, and 0x20 never appears.
- CLEAR_DATA_ON_BUBBLE=1: drain to EMPTY → pc_out=0 and val1=0. With the parameter at 0 → pc_out keeps its last value while wb_en=0.
